// File: rtl/huffman_bit_unpacker.sv
// Huffman decoder front end: packs incoming bytes into an MSB-aligned bit buffer
// and exposes a look-ahead window from which the decoder retires variable-length codes.
module huffman_bit_unpacker #(
    parameter int BUF_W = 32,
    parameter int WIN_W = 16,
    parameter int CNT_W = 6,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic [WIN_W-1:0] win_data,
    output logic [CNT_W-1:0] win_count,
    output logic             win_full,
    input  logic             consume_en,
    input  logic [LEN_W-1:0] consume_len,
    output logic             stream_done,
    output logic             err_underflow
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] WIN_CNT   = CNT_W'(WIN_W);
    localparam logic [CNT_W-1:0] BYTE_CNT  = CNT_W'(8);
    localparam logic [CNT_W-1:0] RDY_LIMIT = CNT_W'(BUF_W - 8);

    logic [BUF_W-1:0] buf_r;
    logic [CNT_W-1:0] count_r;
    logic [1:0]       state_r;
    logic             err_r;

    logic [BUF_W-1:0] buf_next_s;
    logic [CNT_W-1:0] count_next_s;
    logic [1:0]       state_next_s;
    logic             err_next_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             consume_legal_s;
    logic [CNT_W-1:0] len_ext_s;
    logic [CNT_W-1:0] shift_s;
    logic [CNT_W-1:0] rem_s;
    logic [BUF_W-1:0] shifted_s;
    logic [BUF_W-1:0] byte_pos_s;

    // Handshake readiness depends only on registered state, never on this cycle's consume.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == ST_RUN) begin
            in_ready_s = (count_r <= RDY_LIMIT);
        end else begin
            in_ready_s = 1'b0;
        end
    end

    // Datapath: retire legal consume bits, then append an accepted byte right below the survivors.
    always_comb begin
        len_ext_s       = CNT_W'(consume_len);
        accept_s        = in_valid && in_ready_s;
        consume_legal_s = consume_en && (len_ext_s <= count_r) && (len_ext_s <= WIN_CNT);
        shift_s         = consume_legal_s ? len_ext_s : {CNT_W{1'b0}};
        rem_s           = count_r - shift_s;
        shifted_s       = buf_r << shift_s;
        byte_pos_s      = {in_data, {(BUF_W-8){1'b0}}} >> rem_s;
        if (accept_s) begin
            buf_next_s   = shifted_s | byte_pos_s;
            count_next_s = rem_s + BYTE_CNT;
        end else begin
            buf_next_s   = shifted_s;
            count_next_s = rem_s;
        end
        if (consume_en && !consume_legal_s) begin
            err_next_s = 1'b1;
        end else begin
            err_next_s = err_r;
        end
    end

    // Stream-level sequencing: RUN until the last byte, DRAIN until empty, DONE until restart.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s && in_last) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (count_next_s == {CNT_W{1'b0}}) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (restart) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // State registers; a restart out of DONE wipes the buffer and the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_r   <= {BUF_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            state_r <= ST_RUN;
            err_r   <= 1'b0;
        end else if (state_r == ST_DONE && restart) begin
            buf_r   <= {BUF_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            state_r <= ST_RUN;
            err_r   <= 1'b0;
        end else begin
            buf_r   <= buf_next_s;
            count_r <= count_next_s;
            state_r <= state_next_s;
            err_r   <= err_next_s;
        end
    end

    assign in_ready      = in_ready_s;
    assign win_data      = buf_r[BUF_W-1 -: WIN_W];
    assign win_count     = count_r;
    assign win_full      = (count_r >= WIN_CNT);
    assign stream_done   = (state_r == ST_DONE);
    assign err_underflow = err_r;

endmodule

// File: tb/tb_huffman_bit_unpacker.sv
// Directed self-checking bench for huffman_bit_unpacker with hand-computed expectations.
module tb_huffman_bit_unpacker;

    logic        clk;
    logic        rst;
    logic        restart;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] win_data;
    logic [5:0]  win_count;
    logic        win_full;
    logic        consume_en;
    logic [4:0]  consume_len;
    logic        stream_done;
    logic        err_underflow;

    int n_checks;
    int n_fail;

    huffman_bit_unpacker dut (
        .clk(clk), .rst(rst), .restart(restart),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .win_data(win_data), .win_count(win_count), .win_full(win_full),
        .consume_en(consume_en), .consume_len(consume_len),
        .stream_done(stream_done), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        consume_en = 1'b0; consume_len = 5'd0; restart = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        in_valid = 1'b1; in_data = d; in_last = last;
        tick();
        idle();
    endtask

    task automatic consume(input logic [4:0] n);
        consume_en = 1'b1; consume_len = n;
        tick();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({in_ready, win_data, win_count, win_full, stream_done, err_underflow} !== {1'b1, 16'h0000, 6'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: rdy=%b win=%h cnt=%0d full=%b done=%b err=%b, want 1 0000 0 0 0 0",
                     in_ready, win_data, win_count, win_full, stream_done, err_underflow);
        end
    endtask

    task automatic test_fill();
        do_reset();
        push(8'hA5, 1'b0);
        n_checks++;
        if (win_count !== 6'd8 || win_data !== 16'hA500 || win_full !== 1'b0) begin
            n_fail++;
            $display("FAIL fill1: cnt=%0d win=%h full=%b, want 8 a500 0", win_count, win_data, win_full);
        end
        push(8'h3C, 1'b0);
        n_checks++;
        if (win_count !== 6'd16 || win_data !== 16'hA53C || win_full !== 1'b1) begin
            n_fail++;
            $display("FAIL fill2: cnt=%0d win=%h full=%b, want 16 a53c 1", win_count, win_data, win_full);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        n_checks++;
        if (win_count !== 6'd32 || in_ready !== 1'b0 || win_data !== 16'h1122) begin
            n_fail++;
            $display("FAIL full32: cnt=%0d rdy=%b win=%h, want 32 0 1122", win_count, in_ready, win_data);
        end
        // byte offered while full must be dropped
        push(8'hFF, 1'b0);
        n_checks++;
        if (win_count !== 6'd32 || win_data !== 16'h1122) begin
            n_fail++;
            $display("FAIL full_drop: cnt=%0d win=%h, want 32 1122", win_count, win_data);
        end
        consume(5'd3);
        n_checks++;
        if (win_count !== 6'd29 || in_ready !== 1'b0 || win_data !== 16'h8911) begin
            n_fail++;
            $display("FAIL cons3: cnt=%0d rdy=%b win=%h, want 29 0 8911", win_count, in_ready, win_data);
        end
        consume(5'd5);
        n_checks++;
        if (win_count !== 6'd24 || in_ready !== 1'b1 || win_data !== 16'h2233) begin
            n_fail++;
            $display("FAIL cons5: cnt=%0d rdy=%b win=%h, want 24 1 2233", win_count, in_ready, win_data);
        end
        consume(5'd17);
        n_checks++;
        if (win_count !== 6'd24 || err_underflow !== 1'b1 || win_data !== 16'h2233) begin
            n_fail++;
            $display("FAIL over_win: cnt=%0d err=%b win=%h, want 24 1 2233", win_count, err_underflow, win_data);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(8'hA5, 1'b0);
        push(8'h3C, 1'b0);
        in_valid = 1'b1; in_data = 8'hF0; consume_en = 1'b1; consume_len = 5'd4;
        tick();
        idle();
        n_checks++;
        if (win_count !== 6'd20 || win_data !== 16'h53CF || err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b: cnt=%0d win=%h err=%b, want 20 53cf 0", win_count, win_data, err_underflow);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        push(8'hA5, 1'b0);
        consume(5'd3);
        consume(5'd0);
        n_checks++;
        if (win_count !== 6'd5 || win_data !== 16'h2800 || err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len: cnt=%0d win=%h err=%b, want 5 2800 0", win_count, win_data, err_underflow);
        end
        consume(5'd6);
        n_checks++;
        if (win_count !== 6'd5 || win_data !== 16'h2800 || err_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow: cnt=%0d win=%h err=%b, want 5 2800 1", win_count, win_data, err_underflow);
        end
        tick();
        tick();
        n_checks++;
        if (err_underflow !== 1'b1 || win_count !== 6'd5) begin
            n_fail++;
            $display("FAIL sticky: err=%b cnt=%0d, want 1 5", err_underflow, win_count);
        end
    endtask

    task automatic test_end_of_stream();
        do_reset();
        push(8'h80, 1'b0);
        push(8'h01, 1'b1);
        n_checks++;
        if (in_ready !== 1'b0 || win_count !== 6'd16 || stream_done !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_entry: rdy=%b cnt=%0d done=%b, want 0 16 0", in_ready, win_count, stream_done);
        end
        restart = 1'b1;
        tick();
        idle();
        n_checks++;
        if (in_ready !== 1'b0 || win_count !== 6'd16 || stream_done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_ignored: rdy=%b cnt=%0d done=%b, want 0 16 0", in_ready, win_count, stream_done);
        end
        consume(5'd7);
        n_checks++;
        if (win_count !== 6'd9 || win_data !== 16'h0080 || stream_done !== 1'b0) begin
            n_fail++;
            $display("FAIL drain7: cnt=%0d win=%h done=%b, want 9 0080 0", win_count, win_data, stream_done);
        end
        consume(5'd9);
        n_checks++;
        if (win_count !== 6'd0 || stream_done !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done: cnt=%0d done=%b rdy=%b, want 0 1 0", win_count, stream_done, in_ready);
        end
        restart = 1'b1;
        tick();
        idle();
        n_checks++;
        if (in_ready !== 1'b1 || stream_done !== 1'b0 || win_count !== 6'd0) begin
            n_fail++;
            $display("FAIL restart: rdy=%b done=%b cnt=%0d, want 1 0 0", in_ready, stream_done, win_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        push(8'h12, 1'b0);
        push(8'h34, 1'b1);
        consume(5'd4);
        consume(5'd16);
        n_checks++;
        if (win_count !== 6'd12 || err_underflow !== 1'b1 || win_data !== 16'h2340) begin
            n_fail++;
            $display("FAIL pre_rst: cnt=%0d err=%b win=%h, want 12 1 2340", win_count, err_underflow, win_data);
        end
        rst = 1'b1; consume_en = 1'b1; consume_len = 5'd4;
        tick();
        rst = 1'b0;
        idle();
        n_checks++;
        if (win_count !== 6'd0 || in_ready !== 1'b1 || err_underflow !== 1'b0 || stream_done !== 1'b0 || win_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_drain: cnt=%0d rdy=%b err=%b done=%b win=%h, want 0 1 0 0 0000",
                     win_count, in_ready, err_underflow, stream_done, win_data);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        idle();
        test_reset();
        test_fill();
        test_backpressure();
        test_back_to_back();
        test_underflow();
        test_end_of_stream();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/huffman_bit_unpacker.md
Name: huffman_bit_unpacker

Overview:
- Upstream stage of the Huffman decoder: accepts compressed bytes over a valid/ready handshake and keeps them in an MSB-first bit buffer.
- Presents a fixed-width look-ahead window of the next unconsumed bits to the decoder.
- The decoder retires a variable number of bits per cycle (its matched code length) through a consume strobe.
- Tracks end of stream and reports an underflow error when the consumer over-reads.

Parameters:
BUF_W, 32, bit-buffer width; multiple of 8, >= WIN_W+8
WIN_W, 16, look-ahead window width presented to the decoder
CNT_W, 6, width of the bit-count fields; must hold BUF_W
LEN_W, 5, width of consume_len; must hold WIN_W

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
restart  input  1  one-cycle pulse; leaves DONE for a new stream
in_data  input  8  compressed byte; bit 7 is the first bit of the stream
in_valid  input  1  in_data/in_last valid
in_ready  output  1  byte accepted when in_valid && in_ready
in_last  input  1  marks the final byte of the stream
win_data  output  WIN_W  next unconsumed bits, MSB = oldest; bits beyond win_count are 0
win_count  output  CNT_W  number of valid bits in the buffer (0..BUF_W)
win_full  output  1  win_count >= WIN_W
consume_en  input  1  retire consume_len bits this cycle
consume_len  input  LEN_W  bits to retire (0..WIN_W)
stream_done  output  1  high in DONE state
err_underflow  output  1  sticky; set on an illegal consume

Behaviour:
- Reset (rst=1 at a clk edge): buffer=0, count=0, state=RUN, err_underflow=0. Resulting outputs: in_ready=1, win_data=0, win_count=0, win_full=0, stream_done=0.
- Buffer is MSB-aligned. win_data = buf[BUF_W-1 -: WIN_W]. Invariant: all bits at positions below the valid region are 0.
- Legal consume: consume_en=1, consume_len <= count and consume_len <= WIN_W.
- Illegal consume: err_underflow<=1; buffer and count unchanged by the consume; a simultaneous byte accept still proceeds.
- consume_len=0 with consume_en=1 is legal and a no-op.
- in_ready is combinational from registered state only:
  - RUN: in_ready = (count <= BUF_W-8).
  - DRAIN and DONE: in_ready = 0.
  - in_ready does not depend on consume_en (no same-cycle credit).
- Per-cycle update, with c = legal consume length or 0:
  - tmp = buf << c
  - If a byte is accepted, in_data is OR'd into tmp at bit positions [BUF_W-1-(count-c) -: 8].
  - count_next = count - c + (accept ? 8 : 0).
  - Consume and accept in the same cycle are both applied.
- Latency: an accepted byte appears in win_data and win_count the cycle after acceptance. A consume takes effect on outputs the next cycle.
- State machine:
  - RUN: accept with in_last=1 -> DRAIN.
  - DRAIN: count_next==0 -> DONE.
  - DONE: stream_done=1. restart -> RUN with count, buffer and err_underflow cleared.
  - Accepting a final byte whose count_next would already be 0 is impossible (acceptance adds 8), so DRAIN is always entered first.
- restart outside DONE is ignored. rst overrides everything, including mid-stream and mid-consume.
- Arithmetic: count fits in CNT_W with no wrap, guaranteed by in_ready gating. Shifts by 0..WIN_W only.

Test Plan:
1. Reset, then bytes 0xA5, 0x3C with no consume -> win_count 8 then 16; win_data=0xA53C; win_full=1.
2. Fill to 32 bits with bytes 0x11,0x22,0x33,0x44 -> in_ready=0 at count 32. Consume 3 -> count 29, in_ready stays 0. Consume 5 more -> count 24, in_ready=1. win_data=0x2233 after 8 bits consumed.
3. count=16 holding 0xA53C; same cycle consume_len=4 and accept 0xF0 -> next cycle count=20, win_data=0x53CF.
4. count=5, consume_len=6 -> err_underflow=1 and sticky; count stays 5; win_data unchanged.
5. Bytes 0x80 then 0x01 with in_last=1 on 0x01 -> in_ready drops after acceptance. Consume 7, then 9 -> stream_done=1 the cycle after count hits 0. restart -> in_ready=1, stream_done=0.
6. rst asserted mid-DRAIN with count=12 -> next cycle count=0, state RUN, in_ready=1, err_underflow=0.
